wb_stage: RTL and testbench

//   Write-back stage directly downstream of the memory stage. Accepts one retired instruction
//   per handshake and commits its result to the R (int), F (float) or M (matrix) register file.

---
 rtl/wb_stage.sv | 182 ++++++++++++++++++
 tb/tb_wb_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- write-back stage, directly downstream of the memory stage.
//
// Takes one retired instruction per valid/ready handshake and commits it:
//   - R/F results go out in a single cycle on the shared rf_* port.
//   - A 512-bit M result is streamed to the matrix file in M_BEATS beats of
//     M_BEAT_W bits. The stage is busy and drops ready while the beats go out.
//   - When pc_opt is set, the instruction's npc is committed to the PC.
//   - Each instruction produces one retire pulse: with its RF strobe, or with
//     its last M beat.
//
// Handshake: an instruction transfers on a rising edge where ME_valid and
// ready are both 1. ready is (state == IDLE) & !rst, and does not depend on
// ME_valid. While ready is 0 the memory stage must hold its instruction
// stable. Every output is registered, and every strobe is high for exactly
// one cycle.
//
// Configuration macro: WB_RETIRE_CNT_EN
//   defined   -> retire_cnt is a live 32-bit wrapping counter of retire pulses
//   undefined -> there is no counter register; retire_cnt is tied to zero
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   ME_valid / ready     upstream handshake
//   rd_group, rd_index   destination (0 none, 1 R, 2 F, 3 M) and register index
//   mem_to_reg           R/F data taken from mem_data instead of res_R/res_F
//   pc_opt, npc          commit npc to the PC
//   res_R/res_F/res_M    ALU results
//   mem_data             load data
//   rf_R_we/rf_F_we      R/F write strobes, rf_idx/rf_data the shared write port
//   rf_M_we, rf_M_idx,
//   rf_M_beat, rf_M_data matrix-file beat write port
//   pc_we, pc_next       PC write port
//   retire, retire_cnt   retire pulse and retired-instruction count
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int M_BEAT_W   = 128,
  parameter int M_BEATS    = 4,
  parameter int BEAT_IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ME_valid,
  output logic                  ready,
  input  logic [1:0]            rd_group,
  input  logic [4:0]            rd_index,
  input  logic                  mem_to_reg,
  input  logic                  pc_opt,
  input  logic [31:0]           npc,
  input  logic [31:0]           res_R,
  input  logic [31:0]           res_F,
  input  logic [511:0]          res_M,
  input  logic [31:0]           mem_data,
  output logic                  rf_R_we,
  output logic                  rf_F_we,
  output logic [4:0]            rf_idx,
  output logic [31:0]           rf_data,
  output logic                  rf_M_we,
  output logic [4:0]            rf_M_idx,
  output logic [BEAT_IDX_W-1:0] rf_M_beat,
  output logic [M_BEAT_W-1:0]   rf_M_data,
  output logic                  pc_we,
  output logic [31:0]           pc_next,
  output logic                  retire,
  output logic [31:0]           retire_cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MWR  = 1'b1;

  localparam logic [1:0] G_R = 2'd1;
  localparam logic [1:0] G_F = 2'd2;
  localparam logic [1:0] G_M = 2'd3;

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(M_BEATS - 1);

  logic [0:0]            state;
  logic [511:0]          m_buf;     // held copy of the M result while beats stream out
  logic [BEAT_IDX_W-1:0] beat_cnt;  // index of the next beat to issue in MWR
  logic                  accept;
  logic                  retire_d;

  assign ready  = (state == S_IDLE) & ~rst;
  assign accept = ME_valid & ready;

  // A retire is due on this edge for any accepted non-M instruction, or
  // when the last M beat is issued. The counter and the pulse both use it,
  // so they always move together.
  always_comb begin
    retire_d = 1'b0;
    if (accept && (rd_group != G_M || M_BEATS == 1))
      retire_d = 1'b1;
    if (state == S_MWR && beat_cnt == LAST_BEAT)
      retire_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      m_buf     <= '0;
      beat_cnt  <= '0;
      rf_R_we   <= 1'b0;
      rf_F_we   <= 1'b0;
      rf_idx    <= '0;
      rf_data   <= '0;
      rf_M_we   <= 1'b0;
      rf_M_idx  <= '0;
      rf_M_beat <= '0;
      rf_M_data <= '0;
      pc_we     <= 1'b0;
      pc_next   <= '0;
      retire    <= 1'b0;
    end else begin
      rf_R_we <= 1'b0;
      rf_F_we <= 1'b0;
      rf_M_we <= 1'b0;
      pc_we   <= 1'b0;
      retire  <= retire_d;

      case (state)
        S_IDLE: begin
          if (accept) begin
            if (pc_opt) begin
              pc_we   <= 1'b1;
              pc_next <= npc;
            end
            case (rd_group)
              G_R, G_F: begin
                rf_idx  <= rd_index;
                rf_data <= mem_to_reg ? mem_data : ((rd_group == G_R) ? res_R : res_F);
                // R0 is hard-wired zero: data is latched but not written.
                rf_R_we <= (rd_group == G_R) && (rd_index != 5'd0);
                rf_F_we <= (rd_group == G_F);
              end
              G_M: begin
                // Beat 0 goes out straight from the input so the accept edge
                // already issues it; the rest come from the held copy.
                m_buf     <= res_M;
                rf_M_we   <= 1'b1;
                rf_M_idx  <= rd_index;
                rf_M_beat <= '0;
                rf_M_data <= res_M[M_BEAT_W-1:0];
                beat_cnt  <= BEAT_IDX_W'(1);
                if (M_BEATS > 1)
                  state <= S_MWR;
              end
              default: ;
            endcase
          end
        end
        S_MWR: begin
          rf_M_we   <= 1'b1;
          rf_M_beat <= beat_cnt;
          rf_M_data <= m_buf[int'(beat_cnt)*M_BEAT_W +: M_BEAT_W];
          // Leave MWR on the edge that issues the last beat, so ready is
          // already back in the cycle where that beat is visible.
          if (beat_cnt == LAST_BEAT)
            state <= S_IDLE;
          else
            beat_cnt <= beat_cnt + BEAT_IDX_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (retire_d)
      cnt_q <= cnt_q + 32'd1;  // wraps naturally at 2^32
  end

  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
//
// The reference model works at the transaction level. When an instruction is
// accepted, the model writes the outputs it expects into a schedule indexed by
// future cycle number: RF strobe or M beats, the PC write and the retire
// pulse. Stage occupancy is modelled as the first cycle in which the stage is
// free again. Committed PC values go through an expected queue. Each cycle the
// DUT outputs are compared against the schedule at the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  localparam int MBW = 128;
  localparam int MB  = 4;
  localparam int BIW = 2;
  localparam int SCHED_N = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic           ME_valid;
  logic           ready;
  logic [1:0]     rd_group;
  logic [4:0]     rd_index;
  logic           mem_to_reg;
  logic           pc_opt;
  logic [31:0]    npc;
  logic [31:0]    res_R;
  logic [31:0]    res_F;
  logic [511:0]   res_M;
  logic [31:0]    mem_data;
  logic           rf_R_we;
  logic           rf_F_we;
  logic [4:0]     rf_idx;
  logic [31:0]    rf_data;
  logic           rf_M_we;
  logic [4:0]     rf_M_idx;
  logic [BIW-1:0] rf_M_beat;
  logic [MBW-1:0] rf_M_data;
  logic           pc_we;
  logic [31:0]    pc_next;
  logic           retire;
  logic [31:0]    retire_cnt;

  wb_stage #(.M_BEAT_W(MBW), .M_BEATS(MB), .BEAT_IDX_W(BIW)) dut (
    .clk(clk), .rst(rst), .ME_valid(ME_valid), .ready(ready),
    .rd_group(rd_group), .rd_index(rd_index), .mem_to_reg(mem_to_reg),
    .pc_opt(pc_opt), .npc(npc), .res_R(res_R), .res_F(res_F), .res_M(res_M),
    .mem_data(mem_data), .rf_R_we(rf_R_we), .rf_F_we(rf_F_we), .rf_idx(rf_idx),
    .rf_data(rf_data), .rf_M_we(rf_M_we), .rf_M_idx(rf_M_idx),
    .rf_M_beat(rf_M_beat), .rf_M_data(rf_M_data), .pc_we(pc_we),
    .pc_next(pc_next), .retire(retire), .retire_cnt(retire_cnt)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic           r_we;
    logic           f_we;
    logic           m_we;
    logic           pc_we;
    logic           retire;
    logic [4:0]     m_idx;
    logic [1:0]     beat;
    logic [MBW-1:0] m_data;
  } exp_t;

  exp_t        sched[0:SCHED_N-1];
  logic [31:0] exp_q[$];     // PC values expected on the next pc_we strobes
  int          vectors = 0;
  int          errors  = 0;
  int          cyc;
  int          free_cyc;     // first cycle in which the stage can accept again
  logic [4:0]  m_rf_idx;
  logic [31:0] m_rf_data;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < SCHED_N; i++) sched[i] = '{default: '0};
    exp_q.delete();
    cyc       = 0;
    free_cyc  = 0;
    m_rf_idx  = '0;
    m_rf_data = '0;
    m_cnt     = '0;
  endtask

  task automatic check_cycle();
    exp_t e;
    e = sched[cyc];
    check("ready",   ready,   cyc >= free_cyc);
    check("rf_R_we", rf_R_we, e.r_we);
    check("rf_F_we", rf_F_we, e.f_we);
    check("rf_M_we", rf_M_we, e.m_we);
    check("pc_we",   pc_we,   e.pc_we);
    check("retire",  retire,  e.retire);
    check("rf_idx",  rf_idx,  m_rf_idx);
    check("rf_data", rf_data, m_rf_data);
    if (e.m_we) begin
      check("rf_M_idx",  rf_M_idx,  e.m_idx);
      check("rf_M_beat", rf_M_beat, e.beat);
      check("rf_M_data", rf_M_data, e.m_data);
    end
    if (e.pc_we && exp_q.size() > 0)
      check("pc_next", pc_next, exp_q.pop_front());
    m_cnt = m_cnt + 32'(e.retire);
`ifdef WB_RETIRE_CNT_EN
    check("retire_cnt", retire_cnt, m_cnt);
`else
    check("retire_cnt_tied", retire_cnt, 32'd0);
`endif
  endtask

  // The model's view of an accepted instruction: what must appear, and when.
  task automatic model_accept();
    int t;
    t = cyc;
    if (pc_opt) begin
      sched[t+1].pc_we = 1'b1;
      exp_q.push_back(npc);
    end
    if (rd_group == 2'd3) begin
      for (int k = 0; k < MB; k++) begin
        sched[t+1+k].m_we   = 1'b1;
        sched[t+1+k].beat   = 2'(k);
        sched[t+1+k].m_idx  = rd_index;
        sched[t+1+k].m_data = res_M[k*MBW +: MBW];
      end
      sched[t+MB].retire = 1'b1;
      free_cyc = t + MB;
    end else begin
      sched[t+1].retire = 1'b1;
      if (rd_group == 2'd1 || rd_group == 2'd2) begin
        m_rf_idx  = rd_index;
        m_rf_data = mem_to_reg ? mem_data : ((rd_group == 2'd1) ? res_R : res_F);
        sched[t+1].r_we = (rd_group == 2'd1) && (rd_index != 5'd0);
        sched[t+1].f_we = (rd_group == 2'd2);
      end
    end
  endtask

  // ---------------- driver ----------------
  // Entered at a falling edge: check this cycle, drive, cross one rising edge.
  task automatic step(input logic v, input logic [1:0] g, input logic [4:0] idx,
                      input logic m2r, input logic pco, input logic [31:0] np,
                      input logic [31:0] rr, input logic [31:0] rf, input logic [31:0] md,
                      input logic [511:0] rm, output logic acc);
    check_cycle();
    ME_valid = v; rd_group = g; rd_index = idx; mem_to_reg = m2r; pc_opt = pco;
    npc = np; res_R = rr; res_F = rf; mem_data = md; res_M = rm;
    acc = v && (cyc >= free_cyc);
    if (acc) model_accept();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, '0, '0, '0, '0, '0, a);
  endtask

  // Reset asserted mid-cycle: outputs must clear at once, and no beat may follow.
  task automatic reset_mid();
    check_cycle();
    #2 rst = 1'b1;
    #1;
    check("rst_rf_M_we",   rf_M_we,    1'b0);
    check("rst_retire",    retire,     1'b0);
    check("rst_pc_we",     pc_we,      1'b0);
    check("rst_ready",     ready,      1'b0);
    check("rst_rf_M_data", rf_M_data,  '0);
    check("rst_cnt",       retire_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_beat",   rf_M_we,    1'b0);
    check("rst_no_retire", retire,     1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    clear_model();
  endtask

  function automatic logic [511:0] rand_m();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic         acc;
    logic [511:0] mpat;
    int           tries;

    ME_valid = 1'b0; rd_group = '0; rd_index = '0; mem_to_reg = 1'b0; pc_opt = 1'b0;
    npc = '0; res_R = '0; res_F = '0; res_M = '0; mem_data = '0;
    clear_model();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready",      ready,      1'b0);
    check("reset_rf_R_we",    rf_R_we,    1'b0);
    check("reset_rf_M_we",    rf_M_we,    1'b0);
    check("reset_retire",     retire,     1'b0);
    check("reset_pc_next",    pc_next,    32'd0);
    check("reset_retire_cnt", retire_cnt, 32'd0);
    rst = 1'b0;
    #1;
    clear_model();

    // R write, R0 write suppressed, F load, PC commit on a none-group op
    step(1'b1, 2'd1, 5'd5, 1'b0, 1'b0, '0, 32'hDEAD_BEEF, '0, '0, '0, acc);
    step(1'b1, 2'd1, 5'd0, 1'b0, 1'b0, '0, 32'h1234_5678, '0, '0, '0, acc);
    step(1'b1, 2'd2, 5'd3, 1'b1, 1'b0, '0, '0, 32'h1111_2222, 32'h3F80_0000, '0, acc);
    step(1'b1, 2'd0, 5'd9, 1'b0, 1'b1, 32'h8000_0010, '0, '0, '0, '0, acc);
    idle(2);

    // M write with distinct beats and a PC commit, then an R op held by upstream
    mpat = {128'hAAAA_0003_AAAA_0003_AAAA_0003_AAAA_0003,
            128'hAAAA_0002_AAAA_0002_AAAA_0002_AAAA_0002,
            128'hAAAA_0001_AAAA_0001_AAAA_0001_AAAA_0001,
            128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0000};
    step(1'b1, 2'd3, 5'd7, 1'b0, 1'b1, 32'h0000_0400, '0, '0, '0, mpat, acc);
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 10) begin
      step(1'b1, 2'd1, 5'd9, 1'b0, 1'b0, '0, 32'hCAFE_0009, '0, '0, '0, acc);
      tries++;
    end
    check("bp_accept_wait", tries, MB);
    idle(2);

    // three back-to-back R writes
    for (int i = 0; i < 3; i++)
      step(1'b1, 2'd1, 5'(i + 1), 1'b0, 1'b0, '0, 32'h100 + 32'(i), '0, '0, '0, acc);
    idle(2);

    // reset while beat 1 of an M write is on the port
    step(1'b1, 2'd3, 5'd12, 1'b0, 1'b0, '0, '0, '0, '0, rand_m(), acc);
    idle(1);
    reset_mid();
    idle(3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ridx;
      ridx = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), ridx,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
           $urandom, $urandom, $urandom, rand_m(), acc);
    end
    idle(MB + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
